// File: rtl/i2s_tdm_deser.sv
// I2S / TDM slave receiver: resynchronises sclk/ws/data into the clk domain,
// deserialises NUM_CH slots per frame and presents one packed frame per vld
// pulse. Frame length is checked on every ws fall (frm_err) and a lock flag
// tracks whether the receiver is following the frame structure.
module i2s_tdm_deser #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32,
    parameter int NUM_CH = 2,
    parameter int DELAY  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     I2S_sclk,
    input  logic                     I2S_ws,
    input  logic                     I2S_data,
    output logic [NUM_CH*DATA_W-1:0] chnnl_data,
    output logic                     vld,
    output logic                     frm_err,
    output logic                     locked
);

    localparam int FRAME_LEN = NUM_CH * SLOT_W;
    localparam int KW        = $clog2(FRAME_LEN + 1);
    localparam int PW        = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int SW        = $clog2(NUM_CH + 1);

    localparam logic [KW-1:0] K_LAST     = KW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] POS_LAST   = PW'(SLOT_W - 1);
    localparam logic [PW-1:0] POS_FIRST  = PW'(DELAY);
    localparam logic [PW-1:0] POS_DLAST  = PW'(DELAY + DATA_W - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_CH - 1);
    localparam logic [SW-1:0] SLOT_END   = SW'(NUM_CH);

    if (SLOT_W < DATA_W + DELAY) begin : g_param_check
        $error("i2s_tdm_deser: SLOT_W must be >= DATA_W + DELAY");
    end

    typedef enum logic {SYNC, RUN} state_t;

    state_t                   state;
    logic                     sclk_s1, sclk_s2, sclk_s3;
    logic                     ws_s1, ws_s2;
    logic                     data_s1, data_s2;
    logic                     ws_prev;
    logic                     rise, ws_fall;
    logic [KW-1:0]            k;
    logic [PW-1:0]            pos, i_pos;
    logic [SW-1:0]            slot, i_slot;
    logic                     past_delay, in_data, last_bit, capture;
    logic                     pend;
    logic [NUM_CH*DATA_W-1:0] shreg;

    // Bring the async serial lines into the clk domain (sclk gets an extra flop for edge detect)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ws_s1   <= 1'b0;
            ws_s2   <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            sclk_s1 <= I2S_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ws_s1   <= I2S_ws;
            ws_s2   <= ws_s1;
            data_s1 <= I2S_data;
            data_s2 <= data_s1;
        end
    end

    // sclk rising-edge strobe and frame-start detection
    always_comb begin
        rise    = sclk_s2 & ~sclk_s3;
        ws_fall = rise & ~ws_s2 & ws_prev;
    end

    // Slot position of the current rise; a ws fall is always position 0 of slot 0
    always_comb begin
        if (ws_fall) begin
            i_pos  = '0;
            i_slot = '0;
        end else if (pos == POS_LAST) begin
            i_pos  = '0;
            i_slot = slot + 1'b1;
        end else begin
            i_pos  = pos + 1'b1;
            i_slot = slot;
        end
    end

    if (DELAY == 0) begin : g_no_delay
        // With no delay every position from 0 onwards can carry data
        always_comb past_delay = 1'b1;
    end else begin : g_delay
        // Skip the leading delay bits of each slot
        always_comb past_delay = (i_pos >= POS_FIRST);
    end

    // Decide whether this rise carries a data bit, and whether it closes the frame
    always_comb begin
        in_data  = past_delay && (i_pos <= POS_DLAST) && (i_slot != SLOT_END);
        last_bit = in_data && (i_slot == SLOT_LAST) && (i_pos == POS_DLAST);
        capture  = rise && in_data && ((state == RUN) || ws_fall);
    end

    // Frame FSM, bit capture and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SYNC;
            k          <= '0;
            pos        <= '0;
            slot       <= '0;
            ws_prev    <= 1'b0;
            shreg      <= '0;
            pend       <= 1'b0;
            chnnl_data <= '0;
            vld        <= 1'b0;
            frm_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            vld     <= 1'b0;
            frm_err <= 1'b0;
            pend    <= 1'b0;
            if (pend) begin
                chnnl_data <= shreg;
                vld        <= 1'b1;
            end
            if (rise) begin
                ws_prev <= ws_s2;
                case (state)
                    SYNC: begin
                        if (ws_fall) begin
                            state  <= RUN;
                            locked <= 1'b1;
                            k      <= '0;
                            pos    <= i_pos;
                            slot   <= i_slot;
                        end
                    end
                    RUN: begin
                        if (ws_fall) begin
                            // restarting the counters drops any partial frame
                            frm_err <= (k != K_LAST);
                            k       <= '0;
                            pos     <= i_pos;
                            slot    <= i_slot;
                        end else if (k == K_LAST) begin
                            frm_err <= 1'b1;
                            locked  <= 1'b0;
                            state   <= SYNC;
                        end else begin
                            k    <= k + 1'b1;
                            pos  <= i_pos;
                            slot <= i_slot;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
            if (capture) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (i_slot == SW'(c)) begin
                        shreg[c*DATA_W +: DATA_W] <= (shreg[c*DATA_W +: DATA_W] << 1) | DATA_W'(data_s2);
                    end
                end
                if (last_bit) begin
                    pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_deser.sv
// Directed bench for i2s_tdm_deser: a stereo I2S instance (defaults) and a
// 4-slot left-justified TDM instance share the serial lines.
module tb_i2s_tdm_deser;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        ws;
    logic        sdata;
    logic [47:0] data2;
    logic        vld2, err2, lock2;
    logic [95:0] data4;
    logic        vld4, err4, lock4;

    int          n_cmp;
    int          n_bad;
    int          vcnt2, ecnt2, vcnt4, ecnt4, both;
    int          v0, e0;
    logic [23:0] chv [4];

    i2s_tdm_deser #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .DELAY(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I2S_sclk   (sclk),
        .I2S_ws     (ws),
        .I2S_data   (sdata),
        .chnnl_data (data2),
        .vld        (vld2),
        .frm_err    (err2),
        .locked     (lock2)
    );

    i2s_tdm_deser #(.DATA_W(24), .SLOT_W(32), .NUM_CH(4), .DELAY(0)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .I2S_sclk   (sclk),
        .I2S_ws     (ws),
        .I2S_data   (sdata),
        .chnnl_data (data4),
        .vld        (vld4),
        .frm_err    (err4),
        .locked     (lock4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (vld2) vcnt2++;
        if (err2) ecnt2++;
        if (vld4) vcnt4++;
        if (err4) ecnt4++;
        if ((vld2 && err2) || (vld4 && err4)) both++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sclk period (160 ns = 16 clk): ws/data change while sclk is low
    task automatic send_bit(input logic w, input logic d);
        sclk  = 1'b0;
        ws    = w;
        sdata = d;
        #80;
        sclk  = 1'b1;
        #80;
    endtask

    // Rises kfrom..kto-1 of a frame built from chv; pad bits are 1, ws low for the first half
    task automatic send_frame(input int nch, input int dly, input int kfrom, input int kto);
        int          s, b;
        logic        w, d;
        logic [23:0] word;
        for (int kk = kfrom; kk < kto; kk++) begin
            s = kk / 32;
            b = kk % 32;
            w = (kk < nch * 16) ? 1'b0 : 1'b1;
            if (b >= dly && b < dly + 24) begin
                word = chv[s];
                d    = word[23 - (b - dly)];
            end else begin
                d = 1'b1;
            end
            send_bit(w, d);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        vcnt2 = 0; ecnt2 = 0; vcnt4 = 0; ecnt4 = 0; both = 0;
        rst_n = 1'b0; sclk = 1'b0; ws = 1'b0; sdata = 1'b0;
        chv[0] = '0; chv[1] = '0; chv[2] = '0; chv[3] = '0;
        #102;

        // Reset state
        chk("rst_data",   96'(data2), 96'(0));
        chk("rst_vld",    96'(vld2),  96'(0));
        chk("rst_ferr",   96'(err2),  96'(0));
        chk("rst_locked", 96'(lock2), 96'(0));
        chk("rst_data4",  data4,      96'(0));
        rst_n = 1'b1;
        #80;

        // Start mid-frame with ws low: must stay unlocked and silent
        v0 = vcnt2;
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'(i));
        for (int i = 0; i < 32; i++) send_bit(1'b1, 1'(i + 1));
        chk("mid_vld",    96'(vcnt2 - v0), 96'(0));
        chk("mid_locked", 96'(lock2),      96'(0));

        // Three clean stereo frames
        chv[0] = 24'hA5A5A5; chv[1] = 24'h5A5A5A;
        v0 = vcnt2; e0 = ecnt2;
        send_frame(2, 1, 0, 64);
        chk("f1_vld",    96'(vcnt2 - v0), 96'(1));
        chk("f1_locked", 96'(lock2),      96'(1));
        chk("f1_data",   96'(data2),      96'(48'h5A5A5A_A5A5A5));
        send_frame(2, 1, 0, 64);
        send_frame(2, 1, 0, 64);
        chk("f3_vld",    96'(vcnt2 - v0), 96'(3));
        chk("f3_data",   96'(data2),      96'(48'h5A5A5A_A5A5A5));
        chk("f3_ferr",   96'(ecnt2 - e0), 96'(0));
        chk("f3_locked", 96'(lock2),      96'(1));

        // Early ws fall at k=40
        chv[0] = 24'h123456; chv[1] = 24'h654321;
        v0 = vcnt2; e0 = ecnt2;
        send_frame(2, 1, 0, 40);
        chk("early_part_vld", 96'(vcnt2 - v0), 96'(0));
        chv[0] = 24'h0F0F0F; chv[1] = 24'hF0F0F0;
        send_frame(2, 1, 0, 64);
        chk("early_ferr",   96'(ecnt2 - e0), 96'(1));
        chk("early_vld",    96'(vcnt2 - v0), 96'(1));
        chk("early_data",   96'(data2),      96'(48'hF0F0F0_0F0F0F));
        chk("early_locked", 96'(lock2),      96'(1));

        // Missing fall: ws held high for 80 rises
        v0 = vcnt2; e0 = ecnt2;
        for (int i = 0; i < 80; i++) send_bit(1'b1, 1'(i));
        chk("miss_ferr",   96'(ecnt2 - e0), 96'(1));
        chk("miss_vld",    96'(vcnt2 - v0), 96'(0));
        chk("miss_locked", 96'(lock2),      96'(0));
        chv[0] = 24'hC3C3C3; chv[1] = 24'h3C3C3C;
        send_frame(2, 1, 0, 64);
        chk("resync_vld",    96'(vcnt2 - v0), 96'(1));
        chk("resync_data",   96'(data2),      96'(48'h3C3C3C_C3C3C3));
        chk("resync_locked", 96'(lock2),      96'(1));
        chk("resync_ferr",   96'(ecnt2 - e0), 96'(1));

        // Reset for 2 clk in the middle of slot 1
        chv[0] = 24'h800001; chv[1] = 24'h7FFFFE;
        v0 = vcnt2;
        send_frame(2, 1, 0, 45);
        sclk = 1'b0;
        #80;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_data",   96'(data2), 96'(0));
        chk("mrst_vld",    96'(vld2),  96'(0));
        chk("mrst_ferr",   96'(err2),  96'(0));
        chk("mrst_locked", 96'(lock2), 96'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(2, 1, 45, 64);
        chk("mrst_drop_vld", 96'(vcnt2 - v0), 96'(0));
        send_frame(2, 1, 0, 64);
        chk("mrst_next_vld",  96'(vcnt2 - v0), 96'(1));
        chk("mrst_next_data", 96'(data2),      96'(48'h7FFFFE_800001));

        // 4-slot TDM, left-justified
        sclk = 1'b0;
        #80;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = vcnt4; e0 = ecnt4;
        send_bit(1'b1, 1'b1);
        chv[0] = 24'h000001; chv[1] = 24'h000002; chv[2] = 24'h000003; chv[3] = 24'hFFFFFF;
        send_frame(4, 0, 0, 128);
        send_frame(4, 0, 0, 128);
        chk("tdm_vld",    96'(vcnt4 - v0), 96'(2));
        chk("tdm_ch3",    96'(data4[95:72]), 96'(24'hFFFFFF));
        chk("tdm_ch0",    96'(data4[23:0]),  96'(24'h000001));
        chk("tdm_data",   data4, 96'hFFFFFF_000003_000002_000001);
        chv[0] = 24'h800001; chv[1] = 24'h123456; chv[2] = 24'h00FF00; chv[3] = 24'hFFFFFF;
        send_frame(4, 0, 0, 128);
        chk("tdm3_vld",    96'(vcnt4 - v0), 96'(3));
        chk("tdm3_data",   data4, 96'hFFFFFF_00FF00_123456_800001);
        chk("tdm3_ferr",   96'(ecnt4 - e0), 96'(0));
        chk("tdm3_locked", 96'(lock4), 96'(1));

        chk("vld_ferr_overlap", 96'(both), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
